// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor: bridges 256-bit cacheline pmem requests to 4-beat 64-bit memory bursts.
module cacheline_burst_adaptor #(
    parameter int s_line   = 256,
    parameter int s_beat   = 64,
    parameter int s_offset = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pmem_address,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [s_line-1:0] pmem_wdata,
    output logic [s_line-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic [31:0]       address_o,
    output logic              read_o,
    output logic              write_o,
    output logic [s_beat-1:0] burst_o,
    input  logic [s_beat-1:0] burst_i,
    input  logic              resp_i
);
    localparam int num_beats = s_line / s_beat;
    localparam int cnt_w = $clog2(num_beats);
    localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);
    localparam logic [31:0] line_mask = ~((32'd1 << s_offset) - 32'd1);

    typedef enum logic [1:0] {IDLE, READ_BURST, WRITE_BURST, DONE} state_t;

    state_t            state_q;
    logic [cnt_w-1:0]  cnt_q;
    logic [31:0]       addr_q;
    logic [s_line-1:0] line_q;
    logic [s_line-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // write first: a writeback must leave before the allocate read
                    if (pmem_write) begin
                        addr_q  <= pmem_address & line_mask;
                        line_q  <= pmem_wdata;
                        cnt_q   <= '0;
                        state_q <= WRITE_BURST;
                    end else if (pmem_read) begin
                        addr_q  <= pmem_address & line_mask;
                        cnt_q   <= '0;
                        state_q <= READ_BURST;
                    end
                end
                READ_BURST: begin
                    if (resp_i) begin
                        line_q[cnt_q*s_beat +: s_beat] <= burst_i;
                        cnt_q <= cnt_q + cnt_w'(1);
                        if (cnt_q == last_beat) begin
                            rdata_q <= {burst_i, line_q[s_line-s_beat-1:0]};
                            state_q <= DONE;
                        end
                    end
                end
                WRITE_BURST: begin
                    if (resp_i) begin
                        cnt_q <= cnt_q + cnt_w'(1);
                        if (cnt_q == last_beat) state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign read_o     = state_q == READ_BURST;
    assign write_o    = state_q == WRITE_BURST;
    assign pmem_resp  = state_q == DONE;
    assign pmem_rdata = rdata_q;
    assign address_o  = (read_o || write_o) ? addr_q : '0;
    assign burst_o    = write_o ? line_q[cnt_q*s_beat +: s_beat] : '0;
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// tb_cacheline_burst_adaptor: randomized transaction-level check of the cacheline burst adaptor.
module tb_cacheline_burst_adaptor;
    logic         clk = 0;
    logic         rst = 0;
    logic [31:0]  pmem_address = 0;
    logic         pmem_read = 0;
    logic         pmem_write = 0;
    logic [255:0] pmem_wdata = 0;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i = 0;
    logic         resp_i = 0;

    int errs = 0;
    int checks = 0;
    logic [255:0] exp_rdata = 0;

    always #5 clk = ~clk;

    cacheline_burst_adaptor dut (
        .clk(clk), .rst(rst),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .address_o(address_o), .read_o(read_o), .write_o(write_o),
        .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic idle_chk(input string tag);
        chk({tag, "_resp"}, pmem_resp, 1'b0);
        chk({tag, "_rd"}, read_o, 1'b0);
        chk({tag, "_wr"}, write_o, 1'b0);
        chk({tag, "_addr"}, address_o, '0);
        chk({tag, "_burst"}, burst_o, '0);
        chk({tag, "_rdata"}, pmem_rdata, exp_rdata);
    endtask

    // One cacheline transaction, starting at a negedge with the DUT idle.
    // plen>0 replays pat LSB-first as the resp_i sequence, else gaps are random.
    task automatic txn(input bit wr, input bit rd_hold, input logic [31:0] addr,
                       input logic [255:0] wd, input logic [15:0] pat, input int plen,
                       input bit fixed_data);
        logic [255:0] line = '0;
        logic [31:0]  exp_addr = addr & 32'hFFFF_FFE0;
        int k = 0;
        int cyc = 0;
        int pi = 0;
        bit r;
        pmem_address = addr;
        pmem_wdata   = wd;
        pmem_write   = wr;
        pmem_read    = !wr || rd_hold;
        resp_i       = 0;
        @(posedge clk);
        while (k < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            chk("read_o", read_o, !wr);
            chk("write_o", write_o, wr);
            chk("address_o", address_o, exp_addr);
            chk("resp_early", pmem_resp, 1'b0);
            chk("burst_o", burst_o, wr ? wd[k*64 +: 64] : 64'd0);
            pmem_address = $urandom;
            pmem_wdata   = rnd256();
            r = (plen > 0) ? ((pi < plen) ? pat[pi] : 1'b1) : ($urandom_range(0, 2) != 0);
            pi++;
            resp_i  = r;
            burst_i = fixed_data ? 64'hA0 + 64'(k) : {$urandom, $urandom};
            if (r) begin
                line[k*64 +: 64] = burst_i;
                k++;
            end
        end
        if (cyc >= 100) chk("burst_timeout", 1'b1, 1'b0);
        @(negedge clk);
        if (!wr) exp_rdata = line;
        chk("resp_pulse", pmem_resp, 1'b1);
        chk("done_rd", read_o, 1'b0);
        chk("done_wr", write_o, 1'b0);
        chk("done_addr", address_o, '0);
        chk("done_burst", burst_o, '0);
        chk("done_rdata", pmem_rdata, exp_rdata);
        resp_i     = 0;
        pmem_write = 0;
        pmem_read  = rd_hold;
        @(negedge clk);
        idle_chk("post");
    endtask

    initial begin
        #1;
        idle_chk("reset");
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        idle_chk("idle0");

        txn(0, 0, 32'h0000_0100, '0, 16'hF, 4, 1);
        chk("rd_line", pmem_rdata, {64'hA3, 64'hA2, 64'hA1, 64'hA0});

        txn(1, 0, 32'h0000_0200, {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 16'b110_0101, 7, 0);

        txn(1, 1, 32'h0000_0300, rnd256(), 16'h0, 0, 0);
        txn(0, 0, 32'h0000_0400, '0, 16'h0, 0, 0);

        txn(0, 0, 32'hDEAD_BEEF, '0, 16'h0, 0, 0);

        // reset in the middle of a read burst
        pmem_address = 32'h0000_0500;
        pmem_read = 1;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            resp_i = 1;
            burst_i = {$urandom, $urandom};
        end
        @(negedge clk);
        chk("mid_read", read_o, 1'b1);
        rst = 0;
        resp_i = 0;
        pmem_read = 0;
        #1;
        exp_rdata = '0;
        idle_chk("async_rst");
        @(negedge clk);
        idle_chk("rst_hold");
        rst = 1;
        @(negedge clk);
        idle_chk("rst_rel");
        txn(0, 0, 32'h0000_0600, '0, 16'h0, 0, 0);

        // stray beats while idle
        for (int i = 0; i < 3; i++) begin
            resp_i = 1;
            burst_i = {$urandom, $urandom};
            @(negedge clk);
            idle_chk("stray");
        end
        resp_i = 0;

        for (int n = 0; n < 25; n++) begin
            bit w = $urandom_range(0, 1) == 1;
            txn(w, w && ($urandom_range(0, 3) == 0), $urandom, rnd256(), 16'h0, 0, 0);
            if (pmem_read) txn(0, 0, $urandom, '0, 16'h0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
- Bridges the cache's 256-bit physical-memory port to the 64-bit burst memory interface.
- On the cache side it is the responder for pmem_read/pmem_write cacheline transactions.
- On the memory side it is the initiator of 4-beat bursts.
- It sits between the cache datapath/control pair (or the cache arbiter) and main memory. It latches the request, serialises or deserialises the line, and returns a single-cycle pmem_resp.

Parameters:
- s_line, 256, cacheline width in bits
- s_beat, 64, burst beat width in bits
- s_offset, 5, byte-offset bits in a line; the address is line-aligned by clearing these bits
- num_beats, s_line/s_beat (4), beats per transaction

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- pmem_address  in  32  cache-side line address
- pmem_read  in  1  cache read request, held until pmem_resp
- pmem_write  in  1  cache write request, held until pmem_resp
- pmem_wdata  in  s_line  line to write
- pmem_rdata  out  s_line  assembled read line
- pmem_resp  out  1  one-cycle completion pulse
- address_o  out  32  burst address, line-aligned
- read_o  out  1  burst read request
- write_o  out  1  burst write request
- burst_o  out  s_beat  write beat data
- burst_i  in  s_beat  read beat data
- resp_i  in  1  memory beat-valid/accept strobe

Behaviour:
- Clocking and reset: single clock domain. When rst is low, asynchronously:
  - state=IDLE, beat counter=0
  - latched address, latched line and pmem_rdata cleared to 0
  - all outputs 0
- FSM states: IDLE, READ_BURST, WRITE_BURST, DONE.
- IDLE:
  - pmem_write=1 → latch {pmem_address[31:s_offset], s_offset'b0} and pmem_wdata; counter=0; go to WRITE_BURST.
  - else pmem_read=1 → latch address; counter=0; go to READ_BURST.
  - Write has priority if both are high. The read stays pending and is served after the write completes, since the requester holds it.
  - resp_i and burst_i are ignored in IDLE.
- READ_BURST:
  - read_o=1 and address_o=latched address, both driven from registered state (no combinational path from pmem_*).
  - Each cycle with resp_i=1 writes burst_i into line slice [counter*s_beat +: s_beat]; beat 0 is bits [63:0]. Counter then increments.
  - resp_i=0 cycles hold the counter; gaps between beats are legal.
  - When the beat with counter=num_beats-1 is captured, go to DONE.
- WRITE_BURST:
  - write_o=1, address_o=latched address, burst_o = latched line slice [counter*s_beat +: s_beat], combinational from counter.
  - Each resp_i=1 counts as one accepted beat; counter increments.
  - The last beat accepted goes to DONE.
- DONE:
  - pmem_resp=1 for exactly this one cycle; read_o=write_o=0.
  - For reads, pmem_rdata equals the full assembled line in this cycle.
  - Unconditionally go to IDLE.
- Latency: the minimum cycle count is the same for both directions, with resp_i high every cycle.
  - Cycle 0: request sampled in IDLE.
  - Cycles 1–4: read_o or write_o high and beats transferred.
  - Cycle 5: pmem_resp.
  - Each resp_i=0 gap adds one cycle.
- pmem_rdata is registered and holds the last completed read line until the next read burst overwrites it. It is not cleared by writes.
- burst_o is 0 outside WRITE_BURST; address_o is 0 in IDLE and DONE.
- A new request is never accepted in the DONE cycle. There is at least one IDLE cycle between transactions, so a requester that deasserts on the edge after pmem_resp is never double-served.
- Counter width is $clog2(num_beats). It never wraps within a burst, because the last beat forces the exit.
- Address masking: offset bits in pmem_address are discarded. address_o for pmem_address=32'h1234_567F is 32'h1234_5660.
- Reset mid-burst returns to IDLE immediately, with no pmem_resp and the partial line discarded. The memory side must be reset together with this block.
- A requester changing pmem_address or pmem_wdata mid-transaction has no effect, because both are latched.

Test Plan:
- Read, no gaps: pmem_read=1, addr 32'h0000_0100; resp_i=1 for 4 cycles with burst_i=64'hA0,A1,A2,A3 → read_o high cycles 1–4, address_o=32'h100, pmem_resp pulse cycle 5, pmem_rdata={A3,A2,A1,A0}.
- Write with gaps: pmem_write=1, wdata={D3,D2,D1,D0}, resp_i pattern 1,0,1,0,0,1,1 → burst_o shows D0,D1,D1,D2,D2,D2,D3; exactly 4 beats accepted; pmem_resp one cycle after the last accepted beat; write_o low in DONE.
- Simultaneous pmem_read and pmem_write (writeback then allocate), both held → full write burst, DONE, one IDLE cycle, then read burst; two pmem_resp pulses, write first.
- Unaligned address 32'hDEAD_BEEF on a read → address_o=32'hDEAD_BEE0 for all beats.
- Reset asserted (rst=0) after 2 read beats → outputs 0 immediately; no pmem_resp; after release, a new read completes normally with a fresh line.
- Stray resp_i=1 in IDLE → no state change, no pmem_resp, pmem_rdata unchanged.
